// File: rtl/axil_initiator_adaptor.sv
// axil_initiator_adaptor: turns a cmd/resp stream into single-outstanding AXI4-Lite manager transactions.
// Ports:
//   clk_i, reset_n_i         clock and asynchronous active-low reset
//   cmd_*                    request stream: valid/ready, byte address, wr_en, size (log2 bytes), LSB-aligned wdata
//   resp_*                   completion stream: valid/ready, LSB-aligned zero-extended rdata, err
//   m_axil_aw*/w*/b*/ar*/r*  AXI4-Lite manager channels; all outputs registered
// Optional feature: define AXIL_INIT_ALIGN_CHECK_EN to reject misaligned or size-3 commands
// locally, without any AXI traffic.
module axil_initiator_adaptor #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    localparam int size_width_lp = $clog2($clog2(axil_data_width_p/8)+1),
    localparam int strb_width_lp = axil_data_width_p/8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         cmd_v_i,
    output logic                         cmd_ready_and_o,
    input  logic [axil_addr_width_p-1:0] cmd_addr_i,
    input  logic                         cmd_wr_en_i,
    input  logic [size_width_lp-1:0]     cmd_data_size_i,
    input  logic [axil_data_width_p-1:0] cmd_wdata_i,
    output logic                         resp_v_o,
    input  logic                         resp_ready_and_i,
    output logic [axil_data_width_p-1:0] resp_rdata_o,
    output logic                         resp_err_o,
    output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
    output logic [2:0]                   m_axil_awprot_o,
    output logic                         m_axil_awvalid_o,
    input  logic                         m_axil_awready_i,
    output logic [axil_data_width_p-1:0] m_axil_wdata_o,
    output logic [strb_width_lp-1:0]     m_axil_wstrb_o,
    output logic                         m_axil_wvalid_o,
    input  logic                         m_axil_wready_i,
    input  logic [1:0]                   m_axil_bresp_i,
    input  logic                         m_axil_bvalid_i,
    output logic                         m_axil_bready_o,
    output logic [axil_addr_width_p-1:0] m_axil_araddr_o,
    output logic [2:0]                   m_axil_arprot_o,
    output logic                         m_axil_arvalid_o,
    input  logic                         m_axil_arready_i,
    input  logic [axil_data_width_p-1:0] m_axil_rdata_i,
    input  logic [1:0]                   m_axil_rresp_i,
    input  logic                         m_axil_rvalid_i,
    output logic                         m_axil_rready_o
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RESP} state_e;

    state_e                         state_q, state_d;
    logic [axil_addr_width_p-1:0]   addr_q, addr_d;
    logic [1:0]                     size_q, size_d;
    logic [axil_data_width_p-1:0]   wdata_q, wdata_d;
    logic [strb_width_lp-1:0]       wstrb_q, wstrb_d;
    logic                           awvalid_q, awvalid_d;
    logic                           wvalid_q, wvalid_d;
    logic                           bready_q, bready_d;
    logic                           arvalid_q, arvalid_d;
    logic                           rready_q, rready_d;
    logic                           resp_v_q, resp_v_d;
    logic [axil_data_width_p-1:0]   resp_rdata_q, resp_rdata_d;
    logic                           resp_err_q, resp_err_d;

    logic                           cmd_hs;
    logic                           cmd_reject;
    logic [1:0]                     cmd_off;
    logic [1:0]                     cmd_size_eff;
    logic [strb_width_lp-1:0]       strb_base;
    logic [axil_data_width_p-1:0]   rd_mask;
    logic [axil_data_width_p-1:0]   rd_aligned;
    logic                           unused_resp_lsb;

    // Ready is derived from the state register; gated by reset so it drops with the reset.
    assign cmd_ready_and_o = reset_n_i & (state_q == IDLE);
    assign cmd_hs          = cmd_v_i & cmd_ready_and_o;
    assign cmd_off         = cmd_addr_i[1:0];
    // Size 3 behaves like a full word when it is not rejected.
    assign cmd_size_eff    = (cmd_data_size_i == 2'd3) ? 2'd2 : cmd_data_size_i;
    assign strb_base       = (cmd_size_eff == 2'd0) ? 4'h1 : (cmd_size_eff == 2'd1) ? 4'h3 : 4'hF;
    assign rd_mask         = (size_q == 2'd0) ? 32'h0000_00FF : (size_q == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    assign rd_aligned      = (m_axil_rdata_i >> {addr_q[1:0], 3'b000}) & rd_mask;
    // Only bit 1 of a response code distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp_lsb = m_axil_bresp_i[0] ^ m_axil_rresp_i[0];

`ifdef AXIL_INIT_ALIGN_CHECK_EN
    assign cmd_reject = (cmd_data_size_i == 2'd3) | (|(cmd_off & ((2'd1 << cmd_data_size_i) - 2'd1)));
`else
    assign cmd_reject = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_v_d     = resp_v_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d  = cmd_addr_i;
                    size_d  = cmd_size_eff;
                    // Shifts truncate lanes pushed past the top of the word.
                    wdata_d = cmd_wdata_i << {cmd_off, 3'b000};
                    wstrb_d = strb_base << cmd_off;
                    if (cmd_reject) begin
                        resp_v_d     = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (cmd_wr_en_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_A;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; B is only accepted once both have gone.
                awvalid_d = awvalid_q & ~m_axil_awready_i;
                wvalid_d  = wvalid_q & ~m_axil_wready_i;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (m_axil_bvalid_i) begin
                    bready_d     = 1'b0;
                    resp_v_d     = 1'b1;
                    resp_err_d   = m_axil_bresp_i[1];
                    resp_rdata_d = '0;
                    state_d      = RESP;
                end
            end
            RD_A: begin
                if (m_axil_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (m_axil_rvalid_i) begin
                    rready_d     = 1'b0;
                    resp_v_d     = 1'b1;
                    resp_err_d   = m_axil_rresp_i[1];
                    resp_rdata_d = rd_aligned;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready_and_i) begin
                    resp_v_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_v_q     <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_v_q     <= resp_v_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign m_axil_awaddr_o  = addr_q;
    assign m_axil_araddr_o  = addr_q;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_awvalid_o = awvalid_q;
    assign m_axil_wdata_o   = wdata_q;
    assign m_axil_wstrb_o   = wstrb_q;
    assign m_axil_wvalid_o  = wvalid_q;
    assign m_axil_bready_o  = bready_q;
    assign m_axil_arvalid_o = arvalid_q;
    assign m_axil_rready_o  = rready_q;
    assign resp_v_o         = resp_v_q;
    assign resp_rdata_o     = resp_rdata_q;
    assign resp_err_o       = resp_err_q;

endmodule

// File: tb/tb_axil_initiator_adaptor.sv
// tb_axil_initiator_adaptor: randomized self-checking bench with a byte-lane reference model and AXI subordinate.
module tb_axil_initiator_adaptor;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        cmd_v_i, cmd_ready_and_o, cmd_wr_en_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic [1:0]  cmd_data_size_i;
    logic        resp_v_o, resp_ready_and_i, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic [31:0] m_axil_awaddr_o, m_axil_araddr_o, m_axil_wdata_o, m_axil_rdata_i;
    logic [2:0]  m_axil_awprot_o, m_axil_arprot_o;
    logic [3:0]  m_axil_wstrb_o;
    logic        m_axil_awvalid_o, m_axil_awready_i, m_axil_wvalid_o, m_axil_wready_i;
    logic        m_axil_bvalid_i, m_axil_bready_o, m_axil_arvalid_o, m_axil_arready_i;
    logic        m_axil_rvalid_i, m_axil_rready_o;
    logic [1:0]  m_axil_bresp_i, m_axil_rresp_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_initiator_adaptor dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .cmd_addr_i(cmd_addr_i),
        .cmd_wr_en_i(cmd_wr_en_i), .cmd_data_size_i(cmd_data_size_i), .cmd_wdata_i(cmd_wdata_i),
        .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .m_axil_awaddr_o(m_axil_awaddr_o), .m_axil_awprot_o(m_axil_awprot_o), .m_axil_awvalid_o(m_axil_awvalid_o),
        .m_axil_awready_i(m_axil_awready_i), .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
        .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i), .m_axil_bresp_i(m_axil_bresp_i),
        .m_axil_bvalid_i(m_axil_bvalid_i), .m_axil_bready_o(m_axil_bready_o), .m_axil_araddr_o(m_axil_araddr_o),
        .m_axil_arprot_o(m_axil_arprot_o), .m_axil_arvalid_o(m_axil_arvalid_o), .m_axil_arready_i(m_axil_arready_i),
        .m_axil_rdata_i(m_axil_rdata_i), .m_axil_rresp_i(m_axil_rresp_i), .m_axil_rvalid_i(m_axil_rvalid_i),
        .m_axil_rready_o(m_axil_rready_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte-lane view of a transfer: lane off+b carries request byte b.
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                  input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rsp,
                                  output logic rej, output logic [3:0] strb, output logic [31:0] wexp,
                                  output logic [31:0] rexp, output logic err);
        int off, nb;
        off  = int'(addr[1:0]);
        nb   = (size == 2'd3) ? 4 : (1 << size);
        rej  = 1'b0;
`ifdef AXIL_INIT_ALIGN_CHECK_EN
        rej  = (size == 2'd3) || (int'(addr[1:0]) % nb != 0);
`endif
        strb = '0;
        wexp = '0;
        rexp = '0;
        for (int l = 0; l < 4; l++)
            if (l >= off) wexp[8*l +: 8] = wd[8*(l-off) +: 8];
        for (int b = 0; b < nb; b++)
            if (off + b < 4) begin
                strb[off+b] = 1'b1;
                rexp[8*b +: 8] = rd[8*(off+b) +: 8];
            end
        err = rej ? 1'b1 : rsp[1];
        if (wr || rej) rexp = '0;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the response handshake.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                           input int d_a, input int d_w, input int d_b, input int d_resp,
                           input logic [31:0] rd, input logic [1:0] rsp);
        logic rej, err, a_done, w_done, a_hs, w_hs;
        logic [3:0] strb;
        logic [31:0] wexp, rexp;
        int wait_n, resp_cyc, exp_cyc;
        model(wr, addr, size, wd, rd, rsp, rej, strb, wexp, rexp, err);
        exp_cyc = rej ? 1 : wr ? 3 + ((d_a > d_w) ? d_a : d_w) + d_b : 3 + d_a + d_b;
        a_done = 1'b0; w_done = 1'b0; wait_n = 0; resp_cyc = -1;
        check_eq("cmd_ready_idle", {31'd0, cmd_ready_and_o}, 32'd1);
        cmd_v_i = 1'b1; cmd_wr_en_i = wr; cmd_addr_i = addr; cmd_data_size_i = size; cmd_wdata_i = wd;
        resp_ready_and_i = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            cmd_v_i = 1'b0;
            m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0; m_axil_arready_i = 1'b0;
            m_axil_bvalid_i = 1'b0; m_axil_rvalid_i = 1'b0;
            a_hs = 1'b0; w_hs = 1'b0;
            if (rej) check_eq("rej_no_axi", {29'd0, m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o}, 32'd0);
            if (resp_v_o) begin
                resp_cyc = n;
                break;
            end
            check_eq("cmd_ready_busy", {31'd0, cmd_ready_and_o}, 32'd0);
            if (rej) begin
            end else if (wr) begin
                check_eq("arvalid_in_wr", {31'd0, m_axil_arvalid_o}, 32'd0);
                if (!a_done) begin
                    check_eq("awvalid", {31'd0, m_axil_awvalid_o}, 32'd1);
                    check_eq("awaddr", m_axil_awaddr_o, addr);
                    m_axil_awready_i = (n - 1 >= d_a);
                end else check_eq("awvalid_done", {31'd0, m_axil_awvalid_o}, 32'd0);
                if (!w_done) begin
                    check_eq("wvalid", {31'd0, m_axil_wvalid_o}, 32'd1);
                    check_eq("wdata", m_axil_wdata_o, wexp);
                    check_eq("wstrb", {28'd0, m_axil_wstrb_o}, {28'd0, strb});
                    m_axil_wready_i = (n - 1 >= d_w);
                end else check_eq("wvalid_done", {31'd0, m_axil_wvalid_o}, 32'd0);
                if (a_done && w_done) begin
                    if (m_axil_bready_o) begin
                        if (wait_n >= d_b) begin
                            m_axil_bvalid_i = 1'b1;
                            m_axil_bresp_i = rsp;
                        end
                        wait_n++;
                    end
                end else check_eq("bready_early", {31'd0, m_axil_bready_o}, 32'd0);
                a_hs = m_axil_awvalid_o & m_axil_awready_i;
                w_hs = m_axil_wvalid_o & m_axil_wready_i;
            end else begin
                check_eq("aw_w_in_rd", {30'd0, m_axil_awvalid_o, m_axil_wvalid_o}, 32'd0);
                if (!a_done) begin
                    check_eq("arvalid", {31'd0, m_axil_arvalid_o}, 32'd1);
                    check_eq("araddr", m_axil_araddr_o, addr);
                    m_axil_arready_i = (n - 1 >= d_a);
                    check_eq("rready_early", {31'd0, m_axil_rready_o}, 32'd0);
                end else begin
                    check_eq("arvalid_done", {31'd0, m_axil_arvalid_o}, 32'd0);
                    if (m_axil_rready_o) begin
                        if (wait_n >= d_b) begin
                            m_axil_rvalid_i = 1'b1;
                            m_axil_rdata_i = rd;
                            m_axil_rresp_i = rsp;
                        end
                        wait_n++;
                    end
                end
                a_hs = m_axil_arvalid_o & m_axil_arready_i;
            end
            @(posedge clk);
            a_done = a_done | a_hs;
            w_done = w_done | w_hs;
        end
        check_eq("resp_cycle", resp_cyc, exp_cyc);
        if (resp_cyc > 0) begin
            check_eq("resp_rdata", resp_rdata_o, rexp);
            check_eq("resp_err", {31'd0, resp_err_o}, {31'd0, err});
            resp_ready_and_i = (d_resp == 0);
            for (int k = 1; k <= d_resp; k++) begin
                @(negedge clk);
                check_eq("resp_v_held", {31'd0, resp_v_o}, 32'd1);
                check_eq("resp_rdata_held", resp_rdata_o, rexp);
                check_eq("resp_err_held", {31'd0, resp_err_o}, {31'd0, err});
                check_eq("cmd_ready_held", {31'd0, cmd_ready_and_o}, 32'd0);
                resp_ready_and_i = (k == d_resp);
            end
            @(negedge clk);
            resp_ready_and_i = 1'b0;
            check_eq("resp_v_drop", {31'd0, resp_v_o}, 32'd0);
            check_eq("cmd_ready_back", {31'd0, cmd_ready_and_o}, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0;
        cmd_v_i = 1'b0; cmd_wr_en_i = 1'b0; cmd_addr_i = '0; cmd_data_size_i = '0; cmd_wdata_i = '0;
        resp_ready_and_i = 1'b0;
        m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0; m_axil_arready_i = 1'b0;
        m_axil_bvalid_i = 1'b0; m_axil_rvalid_i = 1'b0; m_axil_bresp_i = '0; m_axil_rresp_i = '0; m_axil_rdata_i = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_valids", {26'd0, m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o,
                                m_axil_bready_o, m_axil_rready_o, resp_v_o}, 32'd0);
        reset_n_i = 1'b1;
        @(negedge clk);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready_and_o}, 32'd1);
        check_eq("rst_resp_rdata", resp_rdata_o, 32'd0);
        check_eq("rst_resp_err", {31'd0, resp_err_o}, 32'd0);
        check_eq("rst_awaddr", m_axil_awaddr_o, 32'd0);
        check_eq("rst_araddr", m_axil_araddr_o, 32'd0);
        check_eq("rst_wdata", m_axil_wdata_o, 32'd0);
        check_eq("rst_wstrb_prot", {22'd0, m_axil_wstrb_o, m_axil_awprot_o, m_axil_arprot_o}, 32'd0);

        run_txn(1'b1, 32'h40, 2'd2, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 2'b00);
        run_txn(1'b0, 32'h43, 2'd0, 32'h0, 0, 0, 0, 0, 32'h11223344, 2'b00);
        run_txn(1'b1, 32'h12, 2'd1, 32'h0000ABCD, 3, 0, 0, 0, 32'h0, 2'b00);
        run_txn(1'b0, 32'h80, 2'd2, 32'h0, 0, 0, 0, 5, 32'hCAFEF00D, 2'b10);
        run_txn(1'b1, 32'h41, 2'd2, 32'h12345678, 0, 0, 1, 0, 32'h0, 2'b11);
        run_txn(1'b0, 32'h22, 2'd3, 32'h0, 1, 0, 2, 1, 32'hA1B2C3D4, 2'b01);

        // Asynchronous reset while waiting for read data.
        cmd_v_i = 1'b1; cmd_wr_en_i = 1'b0; cmd_addr_i = 32'h20; cmd_data_size_i = 2'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_v_i = 1'b0;
        check_eq("rstmid_arvalid", {31'd0, m_axil_arvalid_o}, 32'd1);
        m_axil_arready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axil_arready_i = 1'b0;
        check_eq("rstmid_rready", {31'd0, m_axil_rready_o}, 32'd1);
        #1 reset_n_i = 1'b0;
        #1 check_eq("rstmid_async", {28'd0, m_axil_rready_o, m_axil_arvalid_o, resp_v_o, m_axil_bready_o}, 32'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        check_eq("rstmid_cmd_ready", {31'd0, cmd_ready_and_o}, 32'd1);
        check_eq("rstmid_resp_v", {31'd0, resp_v_o}, 32'd0);

        for (int t = 0; t < 40; t++)
            run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
